// File: rtl/phase_acc_pkg.sv
// rtl/phase_acc_pkg.sv - shared encodings for the phase accumulator controller
//
// Purpose : wrap-mode and FSM state encodings used by the controller,
//           its bus interface and the step-update register.
// Ports   : none (package).

package phase_acc_pkg;

   // Wrap behaviour selected at start. Code 3 is reserved and runs as FREE.
   typedef enum logic [1:0] {
      MODE_FREE    = 2'd0,
      MODE_SYNC    = 2'd1,
      MODE_ONESHOT = 2'd2,
      MODE_RSVD    = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Folds the reserved code onto FREE so the stored mode is always legal.
   function automatic mode_e decode_mode(input logic [1:0] m);
      return (m == 2'd3) ? MODE_FREE : mode_e'(m);
   endfunction

endpackage

// File: rtl/phase_accumulator_ctl_if.sv
// rtl/phase_accumulator_ctl_if.sv - control/step/phase bus of the phase accumulator
//
// Purpose : groups the control pulses, step-update handshake and phase
//           outputs of phase_accumulator_ctl.
// Ports   : master drives start/stop/mode/init_phase/step_in/step_valid and
//           observes step_ready/phase/wrap/done/wrap_cnt; slave is the reverse.

interface phase_accumulator_ctl_if
   import phase_acc_pkg::*;
#(
   parameter int ACC_W   = 16,
   parameter int PHASE_W = 8,
   parameter int CNT_W   = 8
);

   logic               start;
   logic               stop;
   logic [1:0]         mode;
   logic [PHASE_W-1:0] init_phase;
   logic [ACC_W-1:0]   step_in;
   logic               step_valid;
   logic               step_ready;
   logic [PHASE_W-1:0] phase;
   logic               wrap;
   logic               done;
   logic [CNT_W-1:0]   wrap_cnt;

   modport master (
      output start, stop, mode, init_phase, step_in, step_valid,
      input  step_ready, phase, wrap, done, wrap_cnt
   );

   modport slave (
      input  start, stop, mode, init_phase, step_in, step_valid,
      output step_ready, phase, wrap, done, wrap_cnt
   );

endinterface

// File: rtl/phase_accumulator_ctl_step_update_reg.sv
// rtl/phase_accumulator_ctl_step_update_reg.sv - pending frequency-word register
//
// Purpose : holds one captured step word until the controller applies it.
// Ports   : clk, rst_n (async active-low), step_in/step_valid/step_ready
//           handshake, apply (consume pending word), pending (held word),
//           pend_flag (a word is waiting).

module step_update_reg
   import phase_acc_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] step_in,
   input  logic         step_valid,
   input  logic         apply,
   output logic         step_ready,
   output logic [W-1:0] pending,
   output logic         pend_flag
);

   // Only one word may wait at a time; further offers are refused.
   assign step_ready = !pend_flag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= '0;
         pend_flag <= 1'b0;
      end else if (apply) begin
         pend_flag <= 1'b0;
      end else if (step_valid && !pend_flag) begin
         pending   <= step_in;
         pend_flag <= 1'b1;
      end
   end

endmodule

// File: rtl/phase_accumulator_ctl.sv
// rtl/phase_accumulator_ctl.sv - controllable phase accumulator for the waveform LUT
//
// Purpose : ACC_W-bit phase accumulator with FREE/SYNC/ONESHOT wrap modes,
//           deferred step updates, start/stop control, wrap strobe and a
//           saturating wrap counter. phase is the MSB slice of the accumulator.
// Ports   : clk - rising-edge clock
//           en  - asynchronous active-low reset (0 initialise, 1 run)
//           bus - phase_accumulator_ctl_if slave (control, step handshake,
//                 phase/wrap/done/wrap_cnt outputs)

module phase_accumulator_ctl
   import phase_acc_pkg::*;
#(
   parameter int ACC_W       = 16,
   parameter int PHASE_W     = 8,
   parameter int CNT_W       = 8,
   parameter bit UPD_AT_WRAP = 1'b1
) (
   input  logic                   clk,
   input  logic                   en,
   phase_accumulator_ctl_if.slave bus
);

   state_e             state_q, state_d;
   mode_e              mode_q, mode_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]   step_act_q, step_act_d;
   logic [ACC_W-1:0]   init_acc;
   logic [ACC_W-1:0]   pending;
   logic [ACC_W:0]     sum;
   logic               carry;
   logic               run_cycle;
   logic               wrap_event;
   logic               apply;
   logic               pend_flag;
   logic               wrap_q, wrap_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Start phase placed in the accumulator MSBs, fractional bits cleared.
   assign init_acc = ACC_W'(bus.init_phase) << (ACC_W - PHASE_W);

   assign sum   = {1'b0, acc_q} + {1'b0, step_act_q};
   assign carry = sum[ACC_W];

   // start/stop take priority over accumulation, so a carry in such a cycle
   // is discarded rather than counted.
   assign run_cycle  = (state_q == ST_RUN) && !bus.stop && !bus.start;
   assign wrap_event = run_cycle && carry;

   // In RUN the pending word is either held for the period boundary or taken
   // immediately; outside RUN there is no boundary to wait for.
   assign apply = pend_flag &&
                  ((state_q != ST_RUN) || (UPD_AT_WRAP ? wrap_event : 1'b1));

   step_update_reg #(
      .W (ACC_W)
   ) u_step_update (
      .clk        (clk),
      .rst_n      (en),
      .step_in    (bus.step_in),
      .step_valid (bus.step_valid),
      .apply      (apply),
      .step_ready (bus.step_ready),
      .pending    (pending),
      .pend_flag  (pend_flag)
   );

   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_FREE;
         acc_q      <= '0;
         step_act_q <= '0;
         wrap_q     <= 1'b0;
         done_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         acc_q      <= acc_d;
         step_act_q <= step_act_d;
         wrap_q     <= wrap_d;
         done_q     <= done_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.stop) begin
         state_d = ST_IDLE;
      end else if (bus.start) begin
         state_d = ST_RUN;
      end else if (wrap_event && (mode_q == MODE_ONESHOT)) begin
         state_d = ST_DONE;
      end
   end

   always_comb begin
      acc_d      = acc_q;
      mode_d     = mode_q;
      cnt_d      = cnt_q;
      wrap_d     = 1'b0;
      step_act_d = apply ? pending : step_act_q;

      if (bus.stop) begin
         acc_d = init_acc;
      end else if (bus.start) begin
         acc_d  = init_acc;
         cnt_d  = '0;
         mode_d = decode_mode(bus.mode);
      end else if (state_q == ST_RUN) begin
         acc_d = sum[ACC_W-1:0];
         if (carry) begin
            wrap_d = 1'b1;
            if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // SYNC and ONESHOT restart the period exactly at the start phase,
            // dropping the residue that FREE carries over.
            if (mode_q != MODE_FREE) begin
               acc_d = init_acc;
            end
         end
      end else begin
         acc_d = init_acc;
      end

      done_d = (state_d == ST_DONE);
   end

   assign bus.phase    = acc_q[ACC_W-1 -: PHASE_W];
   assign bus.wrap     = wrap_q;
   assign bus.done     = done_q;
   assign bus.wrap_cnt = cnt_q;

endmodule

// File: tb/tb_phase_accumulator_ctl.sv
// tb/tb_phase_accumulator_ctl.sv - scoreboard bench for phase_accumulator_ctl

module tb_phase_accumulator_ctl;

   localparam int     ACC_W   = 16;
   localparam int     PHASE_W = 8;
   localparam int     CNT_W   = 8;
   localparam longint MOD     = 64'd1 << ACC_W;
   localparam int     CNT_MAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [7:0] phase;
      logic       wrap;
      logic       done;
      logic [7:0] cnt;
      logic       ready;
   } obs_t;

   logic clk = 1'b0;
   logic en;
   always #5 clk = ~clk;

   phase_accumulator_ctl_if #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .CNT_W(CNT_W)) bus ();

   phase_accumulator_ctl #(
      .ACC_W(ACC_W), .PHASE_W(PHASE_W), .CNT_W(CNT_W), .UPD_AT_WRAP(1'b1)
   ) dut (
      .clk (clk),
      .en  (en),
      .bus (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   obs_t exp_q[$];

   // Reference model: 0 idle, 1 running, 2 finished.
   int     m_state, m_mode, m_cnt;
   longint m_acc, m_step, m_pend;
   bit     m_pflag, m_wrap;

   bit [1:0] cur_mode;
   bit [7:0] cur_init;

   function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endfunction

   function automatic obs_t model_obs();
      obs_t o;
      o.phase = 8'(m_acc / (MOD / 256));
      o.wrap  = m_wrap;
      o.done  = (m_state == 2);
      o.cnt   = 8'(m_cnt);
      o.ready = !m_pflag;
      return o;
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o.phase = bus.phase;
      o.wrap  = bus.wrap;
      o.done  = bus.done;
      o.cnt   = bus.wrap_cnt;
      o.ready = bus.step_ready;
      return o;
   endfunction

   // Advances the model by one clock with the currently driven inputs.
   task automatic model_edge();
      longint start_acc, sum;
      bit wrapped, take;
      if (!en) begin
         m_state = 0; m_mode = 0; m_cnt = 0; m_acc = 0; m_step = 0;
         m_pend = 0; m_pflag = 0; m_wrap = 0;
         return;
      end
      start_acc = longint'(bus.init_phase) * (MOD / 256);
      sum       = m_acc + m_step;
      wrapped   = (m_state == 1) && !bus.stop && !bus.start && (sum >= MOD);
      take      = m_pflag && ((m_state != 1) || wrapped);
      m_wrap    = wrapped;
      if (take) begin
         m_step  = m_pend;
         m_pflag = 0;
      end else if (!m_pflag && bus.step_valid) begin
         m_pend  = longint'(bus.step_in);
         m_pflag = 1;
      end
      if (bus.stop) begin
         m_state = 0;
         m_acc   = start_acc;
      end else if (bus.start) begin
         m_state = 1;
         m_acc   = start_acc;
         m_cnt   = 0;
         m_mode  = (bus.mode == 2'd3) ? 0 : int'(bus.mode);
      end else if (m_state == 1) begin
         if (wrapped) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            m_acc = (m_mode == 0) ? sum - MOD : start_acc;
            if (m_mode == 2) m_state = 2;
         end else begin
            m_acc = sum;
         end
      end else begin
         m_acc = start_acc;
      end
   endtask

   task automatic drive(input bit st, input bit sp, input bit [1:0] md, input bit [7:0] ip,
                        input bit sv, input bit [15:0] si, input bit e);
      @(negedge clk);
      en             = e;
      bus.start      = st;
      bus.stop       = sp;
      bus.mode       = md;
      bus.init_phase = ip;
      bus.step_valid = sv;
      bus.step_in    = si;
      cur_mode       = md;
      cur_init       = ip;
      model_edge();
      exp_q.push_back(model_obs());
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, cur_mode, cur_init, 1'b0, 16'h0000, 1'b1);
   endtask

   task automatic look(input string nm, input bit [7:0] p, input bit w, input bit d);
      @(posedge clk);
      #2;
      check(nm, {22'h0, bus.phase, bus.wrap, bus.done}, {22'h0, p, w, d});
   endtask

   // Monitor: every clock with an expectation queued is compared against the model.
   initial begin
      obs_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle", 32'(dut_obs()), 32'(e));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit st, sp, sv;
      bit [1:0] md;
      bit [7:0] ip;
      bit [15:0] si;

      en = 1'b1;
      bus.start = 0; bus.stop = 0; bus.mode = 0; bus.init_phase = 0;
      bus.step_in = 0; bus.step_valid = 0;
      cur_mode = 0; cur_init = 0;
      #2 en = 1'b0;
      #1 check("reset", 32'(dut_obs()), 32'({8'h00, 1'b0, 1'b0, 8'h00, 1'b1}));
      drive(0, 0, 0, 8'h40, 0, 0, 0);
      drive(0, 0, 0, 8'h40, 0, 0, 0);

      // 1: FREE, phase-continuous wrap
      drive(0, 0, 0, 8'h40, 1, 16'h3400, 1);
      idle(); idle();
      drive(1, 0, 0, 8'h40, 0, 0, 1);
      look("t1_p0", 8'h40, 0, 0); idle();
      look("t1_p1", 8'h74, 0, 0); idle();
      look("t1_p2", 8'hA8, 0, 0); idle();
      look("t1_p3", 8'hDC, 0, 0); idle();
      look("t1_wrap", 8'h10, 1, 0);
      check("t1_cnt", 32'(bus.wrap_cnt), 32'd1);
      drive(0, 1, 0, 8'h40, 0, 0, 1);

      // 2: SYNC restarts at init phase
      drive(1, 0, 1, 8'h40, 0, 0, 1);
      look("t2_p0", 8'h40, 0, 0); idle();
      look("t2_p1", 8'h74, 0, 0); idle();
      look("t2_p2", 8'hA8, 0, 0); idle();
      look("t2_p3", 8'hDC, 0, 0); idle();
      look("t2_wrap", 8'h40, 1, 0);
      drive(0, 1, 0, 8'h40, 0, 0, 1);

      // 3: step change deferred to the wrap, second offer ignored
      drive(1, 0, 0, 8'h40, 0, 0, 1);
      look("t3_p0", 8'h40, 0, 0); idle();
      look("t3_p1", 8'h74, 0, 0);
      drive(0, 0, 0, 8'h40, 1, 16'h1000, 1);
      look("t3_p2", 8'hA8, 0, 0);
      check("t3_ready_busy", 32'(bus.step_ready), 32'd0);
      drive(0, 0, 0, 8'h40, 1, 16'h2000, 1);
      look("t3_p3", 8'hDC, 0, 0);
      check("t3_ready_held", 32'(bus.step_ready), 32'd0);
      idle();
      look("t3_wrap", 8'h10, 1, 0);
      check("t3_ready_free", 32'(bus.step_ready), 32'd1);
      idle();
      look("t3_p5", 8'h20, 0, 0); idle();
      look("t3_p6", 8'h30, 0, 0);

      // 4: ONESHOT ends in DONE and can be restarted
      drive(0, 1, 0, 8'h00, 0, 0, 1);
      drive(0, 0, 2, 8'h00, 1, 16'h8000, 1);
      idle();
      drive(1, 0, 2, 8'h00, 0, 0, 1);
      look("t4_p0", 8'h00, 0, 0); idle();
      look("t4_p1", 8'h80, 0, 0); idle();
      look("t4_wrap", 8'h00, 1, 1); idle();
      look("t4_hold", 8'h00, 0, 1);
      drive(1, 0, 2, 8'h00, 0, 0, 1);
      look("t4_restart", 8'h00, 0, 0);
      check("t4_cnt", 32'(bus.wrap_cnt), 32'd0);

      // 5: asynchronous reset mid-run with a step pending
      drive(0, 1, 0, 8'h40, 0, 0, 1);
      drive(1, 0, 0, 8'h40, 0, 0, 1);
      idle();
      drive(0, 0, 0, 8'h40, 1, 16'h1234, 1);
      @(posedge clk);
      #3 en = 1'b0;
      #1 check("t5_async", 32'(dut_obs()), 32'({8'h00, 1'b0, 1'b0, 8'h00, 1'b1}));
      drive(0, 0, 0, 8'h40, 0, 0, 0);
      drive(0, 0, 0, 8'h40, 0, 0, 1);
      look("t5_init", 8'h40, 0, 0);

      // 6: start+stop, zero step, counter saturation
      drive(0, 0, 0, 8'h40, 1, 16'h3400, 1);
      idle();
      drive(1, 0, 0, 8'h40, 0, 0, 1);
      idle(); idle();
      drive(1, 1, 0, 8'h40, 0, 0, 1);
      look("t6_ss", 8'h40, 0, 0);
      drive(0, 0, 0, 8'h40, 1, 16'h0000, 1);
      idle();
      drive(1, 0, 0, 8'h40, 0, 0, 1);
      repeat (300) idle();
      look("t6_frozen", 8'h40, 0, 0);
      check("t6_nowrap", 32'(bus.wrap_cnt), 32'd0);
      drive(0, 1, 0, 8'h00, 0, 0, 1);
      drive(0, 0, 0, 8'h00, 1, 16'hFFFF, 1);
      idle();
      drive(1, 0, 0, 8'h00, 0, 0, 1);
      repeat (300) idle();
      @(posedge clk);
      #2 check("t6_sat", 32'(bus.wrap_cnt), 32'hFF);

      // Randomized traffic against the model
      repeat (3000) begin
         st = ($urandom_range(0, 99) < 3);
         sp = ($urandom_range(0, 99) < 2);
         md = 2'($urandom_range(0, 3));
         ip = 8'($urandom);
         sv = ($urandom_range(0, 3) == 0);
         si = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         drive(st, sp, md, ip, sv, si, 1);
      end

      repeat (3) @(negedge clk);
      check("drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/phase_accumulator_ctl.md
Name: phase_accumulator_ctl

Overview:
Parametrised, controllable successor to the 8-bit phase counter in the function-generator datapath. It is an ACC_W-bit phase accumulator whose PHASE_W-bit MSB slice addresses the waveform LUT. Adds three wrap modes (free-running, sync-reload, one-shot), a valid/ready step-update handshake that defers frequency changes to the period boundary, start/stop control, a wrap strobe and a wrap counter. Drives the LUT address and, through wrap, the scope trigger.

Parameters:
ACC_W, 16, accumulator width; step resolution is 2^-ACC_W of a period
PHASE_W, 8, output phase width; phase = acc[ACC_W-1 -: PHASE_W]; PHASE_W <= ACC_W
CNT_W, 8, wrap counter width
UPD_AT_WRAP, 1, 1: pending step applied at wrap; 0: applied the cycle after capture

Ports:
clk  in  1  system clock, rising edge
en  in  1  asynchronous active-low reset (0 = initialise, 1 = run)
start  in  1  one-cycle pulse: begin generation
stop  in  1  one-cycle pulse: return to IDLE
mode  in  2  0 FREE, 1 SYNC, 2 ONESHOT, 3 reserved (treated as FREE); sampled on start
init_phase  in  PHASE_W  start phase; init_acc = {init_phase, (ACC_W-PHASE_W) zeros}
step_in  in  ACC_W  new frequency word
step_valid  in  1  step_in valid
step_ready  out  1  = !pend_flag
phase  out  PHASE_W  registered LUT address
wrap  out  1  one-cycle pulse, coincident with the first post-wrap phase
done  out  1  high in DONE state
wrap_cnt  out  CNT_W  wraps since start, saturating at all-ones

Behaviour:
- Reset (en=0, async): acc=0, step_act=0, pending=0, pend_flag=0, mode_r=FREE, state=IDLE, wrap=0, done=0, wrap_cnt=0, phase=0, step_ready=1.
- States IDLE, RUN, DONE. IDLE: acc<=init_acc every cycle (phase tracks init_phase, one-cycle latency). DONE: acc<=init_acc held, done=1.
- start in IDLE/DONE: acc<=init_acc, wrap_cnt<=0, mode_r<=mode, state<=RUN. start in RUN: restart identically. start and stop in the same cycle: stop wins -> IDLE.
- RUN, each cycle: sum = {1'b0,acc} + step_act (ACC_W+1 bits), carry = sum[ACC_W].
  - No carry: acc<=sum[ACC_W-1:0].
  - Carry: wrap<=1, wrap_cnt<=wrap_cnt+1 (saturating). FREE: acc<=sum[ACC_W-1:0] (phase-continuous). SYNC: acc<=init_acc (jitter-free period restart). ONESHOT: acc<=init_acc, state<=DONE.
- step_act=0: phase frozen, no wrap.
- Step handshake: on step_valid & step_ready, pending<=step_in, pend_flag<=1. While pend_flag=1, step_ready=0 and step_valid is ignored.
- Apply (step_act<=pending, pend_flag<=0):
  - UPD_AT_WRAP=1 in RUN: in the carry cycle. The new step governs the first increment after the wrapped value.
  - UPD_AT_WRAP=0 in RUN: the cycle after capture.
  - IDLE/DONE: the cycle after capture, regardless of parameter.
- stop in RUN: state<=IDLE. Any pending step stays pending and is applied per the IDLE rule.
- Reset mid-operation aborts everything, including a pending step, with no clock edge needed.
- All outputs are registered except step_ready, which is a direct register decode.

Decomposition:
- Package phase_acc_pkg: mode encodings (MODE_FREE, MODE_SYNC, MODE_ONESHOT), state encodings (ST_IDLE, ST_RUN, ST_DONE).
- One sub-module, step_update_reg: pending register, pend_flag and handshake, with an apply input. The top level holds the FSM and accumulator.

Test Plan (ACC_W=16, PHASE_W=8, UPD_AT_WRAP=1):
1. FREE, init_phase=0x40, step 0x3400 loaded in IDLE, start -> phase 0x40,0x74,0xA8,0xDC,0x10 with wrap=1 on 0x10; wrap_cnt=1.
2. Same stimulus in SYNC -> 0x40,0x74,0xA8,0xDC,0x40 with wrap=1 on the second 0x40.
3. FREE, step 0x3400, init 0x40. Send step_in=0x1000 after phase 0x74 -> step_ready=0 until the wrap. Sequence 0x40,0x74,0xA8,0xDC,0x10,0x20,0x30. step_ready=1 the cycle after the wrap. A second step_valid while pending is ignored.
4. ONESHOT, init 0x00, step 0x8000 -> phase 0x00,0x80,0x00 with wrap=1, then done=1 and phase held 0x00. start again -> RUN, wrap_cnt=0.
5. RUN in FREE, drive en=0 between clock edges -> phase=0, wrap=0, done=0, step_ready=1 immediately. After release, state IDLE and phase=init_phase after one clock.
6. start and stop asserted together in RUN -> IDLE, phase=init_phase. step 0 in RUN -> phase constant, no wrap for 300 cycles. 256 wraps with CNT_W=8 -> wrap_cnt saturates at 0xFF.
